fmul2k: RTL

//  Streaming float scale-up: o = i * 2^k, exact (no rounding), the inverse of the halve-by-2 unit.
//  Two-stage valid/ready pipeline in the activation vector engine; undoes pre-scaling after exp/div.

---
 rtl/fmul2k_pkg.sv | 25 ++
 rtl/fmul2k_if.sv | 24 ++
 rtl/fmul2k_lzc.sv | 21 ++
 rtl/fmul2k.sv | 137 +++++++++++++
 4 files changed

// File: rtl/fmul2k_pkg.sv
// Shared floating-point helpers for the vector-engine scaling units.
// Default field widths, operand class enum and the classify function.
package fmul2k_pkg;

  localparam int FP_EXP_W = 8;  // exponent width (BF16)
  localparam int FP_MNT_W = 7;  // stored mantissa width (BF16)
  localparam int FP_K_W   = 4;  // width of the unsigned power-of-two shift

  typedef enum logic [1:0] {
    CLS_ZERO,  // exp == 0, mnt == 0
    CLS_SUB,   // exp == 0, mnt != 0
    CLS_NORM,  // ordinary normal number
    CLS_SPEC   // exp all-ones: Inf or NaN
  } fp_class_e;

  // Width-independent classification from pre-decoded field flags.
  function automatic fp_class_e classify(input logic exp_zero,
                                         input logic exp_ones,
                                         input logic mnt_nz);
    if (exp_ones) return CLS_SPEC;
    if (exp_zero) return mnt_nz ? CLS_SUB : CLS_ZERO;
    return CLS_NORM;
  endfunction

endpackage

// File: rtl/fmul2k_if.sv
// Valid/ready streaming interface of the fmul2k scaling unit.
// The slave modport is the unit itself; master is the surrounding logic.
interface fmul2k_if #(
  parameter int I_DATA = 16,
  parameter int K_W    = 4
);
  logic              i_valid;
  logic              o_ready;
  logic [I_DATA-1:0] i_data;
  logic [K_W-1:0]    i_k;
  logic              o_valid;
  logic              i_ready;
  logic [I_DATA-1:0] o_data;

  modport master (
    output i_valid, i_data, i_k, i_ready,
    input  o_ready, o_valid, o_data
  );

  modport slave (
    input  i_valid, i_data, i_k, i_ready,
    output o_ready, o_valid, o_data
  );
endinterface

// File: rtl/fmul2k_lzc.sv
// Combinational leading-zero counter for a subnormal mantissa.
// Result is meaningful only for a non-zero input (0..W-1).
module fmul2k_lzc #(
  parameter int W  = 7,
  parameter int CW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]  d,
  output logic [CW-1:0] cnt
);

  // Scan from LSB upward so the highest set bit determines the count.
  // NOTE: combinational logic uses blocking '=' and assigns a default first,
  // so every path drives cnt and no latch is inferred.
  always_comb begin
    cnt = '0;
    for (int i = 0; i < W; i++) begin
      if (d[i]) cnt = CW'(W - 1 - i);
    end
  end

endmodule

// File: rtl/fmul2k.sv
// fmul2k: streaming exact float scale-up, o = i * 2^k.
// Two-stage valid/ready pipeline: S1 unpacks/classifies, S2 scales and packs.
// Subnormals are normalised up, zero/Inf/NaN pass unchanged, exponent
// overflow gives signed Inf, or max finite when FMUL2K_SATURATE_EN is defined.
module fmul2k
  import fmul2k_pkg::*;
#(
  parameter int I_EXP  = FP_EXP_W,
  parameter int I_MNT  = FP_MNT_W,
  parameter int K_W    = FP_K_W,
  parameter int I_DATA = I_EXP + I_MNT + 1
) (
  input  logic     clk,
  input  logic     rstn,
  fmul2k_if.slave  bus
);

  localparam int LZ_W = (I_MNT > 1) ? $clog2(I_MNT) : 1;
  localparam int EW   = I_EXP + K_W + 1;  // wide enough that exp+k never wraps
  localparam logic [I_EXP-1:0] EXP_INF   = '1;
  localparam logic [I_EXP-1:0] EXP_MAX   = EXP_INF - 1'b1;
  localparam logic [EW-1:0]    EXP_INF_W = EW'(EXP_INF);

  // Input unpack and classification
  logic             in_sgn;
  logic [I_EXP-1:0] in_exp;
  logic [I_MNT-1:0] in_mnt;
  logic [LZ_W-1:0]  in_lz;
  fp_class_e        in_cls;

  assign in_sgn = bus.i_data[I_DATA-1];
  assign in_exp = bus.i_data[I_DATA-2 -: I_EXP];
  assign in_mnt = bus.i_data[I_MNT-1:0];
  assign in_cls = classify(in_exp == '0, in_exp == EXP_INF, in_mnt != '0);

  fmul2k_lzc #(.W(I_MNT), .CW(LZ_W)) u_lzc (
    .d   (in_mnt),
    .cnt (in_lz)
  );

  // Stage registers and stall control
  logic              s1_valid, s2_valid;
  logic              s1_sgn;
  logic [I_EXP-1:0]  s1_exp;
  logic [I_MNT-1:0]  s1_mnt;
  logic [K_W-1:0]    s1_k;
  fp_class_e         s1_cls;
  logic [LZ_W-1:0]   s1_lz;
  logic [I_DATA-1:0] s2_data;
  logic              s1_adv, s2_adv;

  // A stage advances when it is empty or its successor advances.
  assign s2_adv = ~s2_valid | bus.i_ready;
  assign s1_adv = ~s1_valid | s2_adv;

  assign bus.o_ready = s1_adv;
  assign bus.o_valid = s2_valid;
  assign bus.o_data  = s2_data;

  // S2 scale and pack from the S1 registers
  logic [EW-1:0]     e_new;
  logic              ovf;
  logic [I_MNT-1:0]  mnt_norm;
  logic [I_DATA-1:0] res;

  // Drop the leading one of a subnormal: shift by lz+1, keep the low bits.
  assign mnt_norm = (s1_mnt << s1_lz) << 1;

  // Select result per class; zero and Inf/NaN keep the input word.
  always_comb begin
    e_new = '0;
    ovf   = 1'b0;
    res   = {s1_sgn, s1_exp, s1_mnt};
    case (s1_cls)
      CLS_NORM: begin
        e_new = EW'(s1_exp) + EW'(s1_k);
        ovf   = (e_new >= EXP_INF_W);
        res   = {s1_sgn, e_new[I_EXP-1:0], s1_mnt};
      end
      CLS_SUB: begin
        if (EW'(s1_k) <= EW'(s1_lz)) begin
          res = {s1_sgn, {I_EXP{1'b0}}, s1_mnt << s1_k};
        end else begin
          e_new = EW'(s1_k) - EW'(s1_lz);
          ovf   = (e_new >= EXP_INF_W);
          res   = {s1_sgn, e_new[I_EXP-1:0], mnt_norm};
        end
      end
      default: ;
    endcase
    if (ovf) begin
`ifdef FMUL2K_SATURATE_EN
      res = {s1_sgn, EXP_MAX, {I_MNT{1'b1}}};
`else
      res = {s1_sgn, EXP_INF, {I_MNT{1'b0}}};
`endif
    end
  end

  // S1 register: capture unpacked operand when the stage can advance.
  // NOTE: sequential state uses non-blocking '<=' so all registers update
  // from pre-edge values. Data registers are reset too: the stage is a
  // handful of flops and a clean reset keeps o_data at zero.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid <= 1'b0;
      s1_sgn   <= 1'b0;
      s1_exp   <= '0;
      s1_mnt   <= '0;
      s1_k     <= '0;
      s1_cls   <= CLS_ZERO;
      s1_lz    <= '0;
    end else if (s1_adv) begin
      s1_valid <= bus.i_valid;
      if (bus.i_valid) begin
        s1_sgn <= in_sgn;
        s1_exp <= in_exp;
        s1_mnt <= in_mnt;
        s1_k   <= bus.i_k;
        s1_cls <= in_cls;
        s1_lz  <= in_lz;
      end
    end
  end

  // S2 register: output holding stage, frozen while downstream stalls.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) s2_data <= res;
    end
  end

endmodule
